// File: rtl/io_cfg_pkg.sv
// Shared types and constants for the serial IO configuration loader.
package io_cfg_pkg;

  // Default configuration word width: 6 tracks x (2 inputs + 3 outputs).
  localparam int CW_DEFAULT = 30;

  // Loader FSM states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    PARITY = 3'd2,
    CHECK  = 3'd3,
    COMMIT = 3'd4
  } cfg_state_e;

endpackage

// File: rtl/io_config_check.sv
// Combinational frame checker: even parity over shadow+p, and detection of
// more than one external input driving the same data track.
module io_config_check
  import io_cfg_pkg::*;
#(
  parameter int CW        = CW_DEFAULT,
  parameter int W         = 6,
  parameter int EXTDATAIN = 2
) (
  input  logic [CW-1:0] shadow,
  input  logic          p,
  output logic          parity_ok,
  output logic          conflict
);

  // Even parity: the frame plus its parity bit must hold an even number of ones.
  assign parity_ok = ~(^{shadow, p});

  // Per track, flag a conflict as soon as a second input enable is seen.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    conflict = 1'b0;
    for (int j = 0; j < W; j++) begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < EXTDATAIN; i++) begin
        if (seen && shadow[j + i*W]) conflict = 1'b1;
        seen = seen | shadow[j + i*W];
      end
    end
  end

endmodule

// File: rtl/io_config_loader.sv
// Serial loader for the IO gate switch-enable word: LSB-first frame into a
// shadow register, parity bit, legality check, then atomic commit to c.
module io_config_loader
  import io_cfg_pkg::*;
#(
  parameter  int W          = 6,
  parameter  int WW         = 3,
  parameter  int EXTDATAIN  = 2,
  parameter  int EXTDATAOUT = 3,
  localparam int CW         = W * (EXTDATAIN + EXTDATAOUT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_start,
  input  logic          cfg_bit,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  output logic [CW-1:0] c,
  output logic          cfg_done,
  output logic          cfg_error,
  output logic          scan_out
);

  localparam int              CNT_W = $clog2(CW + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CW - 1);

  // External ports must tile the tracks evenly.
  if ((W % WW) != 0) begin : g_bad_ww
    $error("io_config_loader: W must be a multiple of WW");
  end

  cfg_state_e       state_q, state_d;
  logic [CW-1:0]    shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             parity_ok_q, parity_ok_d;
  logic             err_q, err_d;
  logic [CW-1:0]    c_q, c_d;
  logic             parity_ok, conflict;

  io_config_check #(
    .CW       (CW),
    .W        (W),
    .EXTDATAIN(EXTDATAIN)
  ) u_check (
    .shadow   (shadow_q),
    .p        (cfg_bit),
    .parity_ok(parity_ok),
    .conflict (conflict)
  );

  // Next-state and output decode; restart in SHIFT/PARITY drops the same-cycle bit.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    cnt_d       = cnt_q;
    parity_ok_d = parity_ok_q;
    err_d       = err_q;
    c_d         = c_q;
    cfg_ready   = 1'b0;
    cfg_done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          shadow_d = '0;
          cnt_d    = '0;
          err_d    = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        cfg_ready = 1'b1;
        if (cfg_start) begin
          shadow_d = '0;
          cnt_d    = '0;
        end else if (cfg_valid) begin
          shadow_d = {cfg_bit, shadow_q[CW-1:1]};
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) state_d = PARITY;
        end
      end
      PARITY: begin
        cfg_ready = 1'b1;
        if (cfg_start) begin
          shadow_d = '0;
          cnt_d    = '0;
          state_d  = SHIFT;
        end else if (cfg_valid) begin
          parity_ok_d = parity_ok;
          state_d     = CHECK;
        end
      end
      CHECK: begin
        if (parity_ok_q && !conflict) begin
          state_d = COMMIT;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      COMMIT: begin
        cfg_done = 1'b1;
        c_d      = shadow_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      cnt_q       <= '0;
      parity_ok_q <= 1'b0;
      err_q       <= 1'b0;
      c_q         <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      cnt_q       <= cnt_d;
      parity_ok_q <= parity_ok_d;
      err_q       <= err_d;
      c_q         <= c_d;
    end
  end

  assign c         = c_q;
  assign cfg_error = err_q;
  assign scan_out  = shadow_q[0];

endmodule
